// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-stream select arbiter in front of mux_2to1.
package mux_arb_pkg;

  // Arbiter FSM state: IDLE waits for a request, LOCK owns the mux for one packet or burst.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // mux_2to1 select encodings.
  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  // Default burst limit and beat-counter width.
  localparam int unsigned MAX_BURST_DEF = 8;
  localparam int unsigned CNT_W_DEF     = 4;

endpackage

// File: rtl/arb_beat_counter.sv
// Beat counter for one grant; flags the beat that would reach the burst limit.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        zero the count (wins over inc)
//   inc          count one accepted beat
//   limit_hit_c  combinational: the next beat completes MAX_BURST beats (never set when MAX_BURST=0)
module arb_beat_counter
  import mux_arb_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic limit_hit_c
);

  localparam bit               LIMIT_EN  = (MAX_BURST != 0);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LIMIT_EN ? MAX_BURST - 1 : 0);

  logic [CNT_W-1:0] beat_cnt;

  // Count register; wraps freely when unlimited since only the limit compare reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (inc) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  // Current count equals MAX_BURST-1, so a beat now is the last one allowed.
  assign limit_hit_c = LIMIT_EN && (beat_cnt == LAST_BEAT);

endmodule

// File: rtl/mux2_sel_arbiter.sv
// Round-robin select arbiter for two valid/ready packet streams feeding mux_2to1.
// Holds sel for a whole packet (or up to MAX_BURST beats) and steers the handshakes;
// the data path itself stays in mux_2to1.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in0_valid/last/ready  stream 0 handshake (data on mux din_0)
//   in1_valid/last/ready  stream 1 handshake (data on mux din_1)
//   out_valid, out_ready  merged stream handshake (data on mux_out)
//   sel                   registered mux select, 0 = din_0, 1 = din_1
//   busy                  high while a stream owns the mux
module mux2_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in0_valid,
  input  logic in0_last,
  output logic in0_ready,
  input  logic in1_valid,
  input  logic in1_last,
  output logic in1_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic sel,
  output logic busy
);

  arb_state_e state, state_nxt;
  logic       sel_nxt;
  logic       prio, prio_nxt;
  logic       cnt_clear, cnt_inc;
  logic       limit_hit_c;
  logic       sel_last_c;
  logic       beat_c;

  arb_beat_counter #(
    .CNT_W     (CNT_W),
    .MAX_BURST (MAX_BURST)
  ) u_beat_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (cnt_clear),
    .inc         (cnt_inc),
    .limit_hit_c (limit_hit_c)
  );

  // State, select and priority registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= SEL_IN0;
      prio  <= SEL_IN0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      prio  <= prio_nxt;
    end
  end

  // Next state plus handshake steering; readies only ever follow the registered sel.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    prio_nxt   = prio;
    in0_ready  = 1'b0;
    in1_ready  = 1'b0;
    out_valid  = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    sel_last_c = 1'b0;
    beat_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in0_valid || in1_valid) begin
          // Contention goes to the priority holder, otherwise to the sole requester.
          sel_nxt   = (in0_valid && in1_valid) ? prio : (in1_valid ? SEL_IN1 : SEL_IN0);
          cnt_clear = 1'b1;
          state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        out_valid  = (sel == SEL_IN1) ? in1_valid : in0_valid;
        sel_last_c = (sel == SEL_IN1) ? in1_last  : in0_last;
        in0_ready  = (sel == SEL_IN0) && out_ready;
        in1_ready  = (sel == SEL_IN1) && out_ready;
        beat_c     = out_valid && out_ready;
        if (beat_c) begin
          cnt_inc = 1'b1;
          // End of packet or burst limit: hand priority to the other stream.
          if (sel_last_c || limit_hit_c) begin
            state_nxt = ST_IDLE;
            prio_nxt  = ~sel;
            cnt_clear = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (state == ST_LOCK);

endmodule
